bus_fabric: RTL and testbench



---
 rtl/bus_fabric_pkg.sv | 28 ++
 rtl/bus_fabric_if.sv | 40 ++++
 rtl/bus_fabric_decoder.sv | 29 ++
 rtl/bus_fabric.sv | 132 +++++++++++++
 tb/tb_bus_fabric.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_fabric_pkg.sv
// bus_fabric_pkg: shared types and sizing helpers for the bus fabric slice.
//   state_t      - transaction engine states
//   sel_width()  - width of the slave-select field m_addr[WIDTH-1:SELLSB]
//   idx_width()  - width of a registered slave index
//   cnt_width()  - width of a counter able to hold 0..TIMEOUT
package bus_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int TIMEOUT_DEFAULT = 15;

  function automatic int sel_width(input int width, input int sellsb);
    return width - sellsb;
  endfunction

  function automatic int idx_width(input int nslave);
    return (nslave < 2) ? 1 : $clog2(nslave);
  endfunction

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/bus_fabric_if.sv
// bus_fabric_if: master-side request/response and slave-side access signals.
//   master modport - the core data master (drives requests, takes responses)
//   slave  modport - the peripheral side (takes selects, drives rdata/ack)
//   fabric modport - the transaction engine sitting between the two
interface bus_fabric_if #(
  parameter int WIDTH  = 32,
  parameter int NSLAVE = 4
);
  logic                     m_valid;
  logic                     m_ready;
  logic                     m_write;
  logic [WIDTH-1:0]         m_addr;
  logic [WIDTH-1:0]         m_wdata;
  logic                     m_rvalid;
  logic [WIDTH-1:0]         m_rdata;
  logic                     m_err;
  logic [NSLAVE-1:0]        s_sel;
  logic                     s_write;
  logic [WIDTH-1:0]         s_addr;
  logic [WIDTH-1:0]         s_wdata;
  logic [NSLAVE*WIDTH-1:0]  s_rdata;
  logic [NSLAVE-1:0]        s_ack;

  modport master (
    output m_valid, m_write, m_addr, m_wdata,
    input  m_ready, m_rvalid, m_rdata, m_err
  );

  modport slave (
    input  s_sel, s_write, s_addr, s_wdata,
    output s_rdata, s_ack
  );

  modport fabric (
    input  m_valid, m_write, m_addr, m_wdata,
    output m_ready, m_rvalid, m_rdata, m_err,
    output s_sel, s_write, s_addr, s_wdata,
    input  s_rdata, s_ack
  );
endinterface

// File: rtl/bus_fabric_decoder.sv
// bus_decoder: combinational address decode.
//   addr   in  WIDTH  master byte address
//   hit    out 1      select field names an existing slave
//   idx    out IDXW   slave index (meaningful only when hit)
//   offset out WIDTH  addr with the select field cleared
module bus_decoder
  import bus_fabric_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NSLAVE = 4,
  parameter int SELLSB = 28,
  localparam int SELW  = sel_width(WIDTH, SELLSB),
  localparam int IDXW  = idx_width(NSLAVE)
) (
  input  logic [WIDTH-1:0] addr,
  output logic             hit,
  output logic [IDXW-1:0]  idx,
  output logic [WIDTH-1:0] offset
);

  logic [SELW-1:0] field;

  assign field  = addr[WIDTH-1:SELLSB];
  // Whole-field compare: any stray bit above the index bits forces a miss.
  assign hit    = (32'(field) < 32'(NSLAVE));
  assign idx    = field[IDXW-1:0];
  assign offset = {{SELW{1'b0}}, addr[SELLSB-1:0]};

endmodule

// File: rtl/bus_fabric.sv
// bus_fabric: one master to NSLAVE memory-mapped slaves, one transaction
// outstanding at a time, with decode-error and ack-timeout responses.
//   clk, rst  - clock, synchronous active-high reset
//   bus       - bus_fabric_if.fabric: m_* request/response, s_* slave access
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NSLAVE  = 4,
  parameter int SELLSB  = 28,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  bus_fabric_if.fabric bus
);

  localparam int IDXW  = idx_width(NSLAVE);
  localparam int CNT_W = cnt_width(TIMEOUT);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [NSLAVE-1:0]  sel_q, sel_d;
  logic               write_q, write_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               dec_hit;
  logic [IDXW-1:0]    dec_idx;
  logic [WIDTH-1:0]   dec_off;

  bus_decoder #(
    .WIDTH  (WIDTH),
    .NSLAVE (NSLAVE),
    .SELLSB (SELLSB)
  ) u_dec (
    .addr   (bus.m_addr),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .offset (dec_off)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.m_valid) begin
          if (dec_hit) begin
            state_d = ACCESS;
            idx_d   = dec_idx;
            sel_d   = NSLAVE'(1) << dec_idx;
            write_d = bus.m_write;
            addr_d  = dec_off;
            wdata_d = bus.m_wdata;
            cnt_d   = '0;
          end else begin
            // Decode miss answers straight away without touching any slave.
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      ACCESS: begin
        // Ack is checked before the timeout so a last-cycle ack still succeeds.
        if (bus.s_ack[idx_q]) begin
          state_d = RESP;
          rdata_d = write_q ? '0 : bus.s_rdata[int'(idx_q)*WIDTH +: WIDTH];
          err_d   = 1'b0;
          sel_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
          sel_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.m_ready  = (state_q == IDLE);
  assign bus.m_rvalid = (state_q == RESP);
  assign bus.m_rdata  = rdata_q;
  assign bus.m_err    = err_q;
  assign bus.s_sel    = sel_q;
  assign bus.s_write  = write_q;
  assign bus.s_addr   = addr_q;
  assign bus.s_wdata  = wdata_q;

endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: directed and randomized transactions against bus_fabric,
// with expected latency/data/error derived from the access rules.
module tb_bus_fabric;

  localparam int WIDTH   = 32;
  localparam int NSLAVE  = 4;
  localparam int SELLSB  = 28;
  localparam int TIMEOUT = 15;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bus_fabric_if #(.WIDTH(WIDTH), .NSLAVE(NSLAVE)) bus ();

  bus_fabric #(
    .WIDTH   (WIDTH),
    .NSLAVE  (NSLAVE),
    .SELLSB  (SELLSB),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while the fabric is idle; returns at the negedge of
  // the cycle following the response. dly = wait cycles before the selected
  // slave acks (dly >= TIMEOUT means it never acks). hold keeps m_valid high.
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rd, input int dly, input bit hold);
    int          idx;
    bit          hit;
    int          exp_lat;
    int          exp_sel;
    logic [31:0] exp_rd;
    bit          exp_err;
    logic [3:0]  onehot;
    int          cyc;
    int          selc;
    bit          got;

    idx = int'(addr >> SELLSB);
    hit = (idx < NSLAVE);
    if (!hit) begin
      exp_lat = 1; exp_sel = 0; exp_err = 1'b1; exp_rd = '0;
    end else if (dly < TIMEOUT) begin
      exp_lat = dly + 2; exp_sel = dly + 1; exp_err = 1'b0; exp_rd = wr ? 32'h0 : rd;
    end else begin
      exp_lat = TIMEOUT + 1; exp_sel = TIMEOUT; exp_err = 1'b1; exp_rd = '0;
    end
    onehot = hit ? 4'(1 << idx) : 4'h0;

    chk("ready_idle", bus.m_ready, 1);
    bus.m_valid = 1'b1;
    bus.m_write = wr;
    bus.m_addr  = addr;
    bus.m_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      bus.m_valid = 1'b0;
      bus.m_addr  = $urandom;
      bus.m_wdata = $urandom;
      bus.m_write = 1'($urandom_range(0, 1));
    end

    cyc = 1; selc = 0; got = 1'b0;
    while (!got && cyc <= TIMEOUT + 4) begin
      if (bus.m_rvalid === 1'b1) begin
        got = 1'b1;
        chk("latency", 64'(cyc), 64'(exp_lat));
        chk("m_rdata", bus.m_rdata, exp_rd);
        chk("m_err", bus.m_err, exp_err);
        chk("ready_resp", bus.m_ready, 0);
        chk("sel_resp", bus.s_sel, 0);
      end else begin
        if (bus.s_sel !== 4'h0) begin
          selc++;
          chk("s_sel", bus.s_sel, onehot);
          chk("s_addr", bus.s_addr, addr & 32'h0FFF_FFFF);
          chk("s_write", bus.s_write, wr);
          chk("s_wdata", bus.s_wdata, wd);
          chk("ready_access", bus.m_ready, 0);
        end
        // Unselected slaves ack at random; only the selected one follows dly.
        bus.s_ack   = 4'($urandom);
        bus.s_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (hit) begin
          bus.s_ack[idx] = (selc == dly + 1);
          bus.s_rdata[idx*32 +: 32] = rd;
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk("rvalid_seen", got, 1);
    chk("sel_cycles", 64'(selc), 64'(exp_sel));
    bus.s_ack = '0;
    @(negedge clk);
    chk("rvalid_pulse", bus.m_rvalid, 0);
    chk("err_clear", bus.m_err, 0);
    chk("rdata_hold", bus.m_rdata, exp_rd);
    chk("ready_after", bus.m_ready, 1);
  endtask

  initial begin
    logic [31:0] a;
    int          k;
    bit          saw_rvalid;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.m_valid = 1'b0;
    bus.m_write = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.s_ack   = '0;
    bus.s_rdata = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_ready", bus.m_ready, 1);
    chk("rst_m_rvalid", bus.m_rvalid, 0);
    chk("rst_m_err", bus.m_err, 0);
    chk("rst_m_rdata", bus.m_rdata, 0);
    chk("rst_s_sel", bus.s_sel, 0);
    chk("rst_s_write", bus.s_write, 0);
    chk("rst_s_addr", bus.s_addr, 0);
    chk("rst_s_wdata", bus.s_wdata, 0);
    rst = 1'b0;

    // Zero-wait read from slave 2
    txn(1'b0, 32'h2000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    // Write to slave 1 with 3 wait cycles
    txn(1'b1, 32'h1000_0004, 32'h55, 32'h1234_5678, 3, 1'b0);
    // Decode miss
    txn(1'b0, 32'h5000_0000, 32'h0, 32'hAAAA_AAAA, 0, 1'b0);
    // Stray high select bit also misses
    txn(1'b1, 32'hA000_0000, 32'h77, 32'h0, 0, 1'b0);
    // Slave 3 never acks; others ack at random meanwhile
    txn(1'b0, 32'h3000_0100, 32'h0, 32'hCAFE_F00D, 255, 1'b0);
    // Back-to-back reads with m_valid held high between them
    txn(1'b0, 32'h0000_0020, 32'h0, 32'h0BAD_CAFE, 1, 1'b1);
    txn(1'b0, 32'h2000_0030, 32'h0, 32'h1357_9BDF, 0, 1'b0);
    // Ack arriving in the final timeout cycle wins
    txn(1'b0, 32'h1000_0040, 32'h0, 32'h2468_ACE0, TIMEOUT - 1, 1'b0);

    // Randomized transactions
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 5) == 0) k = int'($urandom_range(4, 15));
      else k = int'($urandom_range(0, 3));
      a = {4'(k), 28'($urandom)};
      txn(1'($urandom_range(0, 1)), a, $urandom, $urandom,
          int'($urandom_range(0, TIMEOUT + 1)), 1'b0);
    end

    // Reset held 3 cycles in the middle of an access
    bus.m_valid = 1'b1;
    bus.m_write = 1'b0;
    bus.m_addr  = 32'h3000_0000;
    @(posedge clk);
    @(negedge clk);
    bus.m_valid = 1'b0;
    bus.s_ack   = '0;
    @(negedge clk);
    chk("mid_sel", bus.s_sel, 4'b1000);
    rst = 1'b1;
    saw_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.m_rvalid !== 1'b0) saw_rvalid = 1'b1;
    end
    chk("rst_hold_sel", bus.s_sel, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_sel", bus.s_sel, 0);
    chk("rel_ready", bus.m_ready, 1);
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      if (bus.m_rvalid !== 1'b0) saw_rvalid = 1'b1;
      @(negedge clk);
    end
    chk("no_resp_after_rst", saw_rvalid, 0);

    // Fabric still works afterwards
    txn(1'b0, 32'h3000_0008, 32'h0, 32'h0F0F_0F0F, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
